// File: rtl/sync_fifo_pkg.sv
// Shared sizing constants, read-port state type and almost-flag helper for sync_fifo_ctrl.
package sync_fifo_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int DEPTH         = 1 << ADDR_SIZE_DEF;
  localparam int PTR_W         = ADDR_SIZE_DEF + 1;
  localparam int CNT_W         = PTR_W;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_e;

  // {almost_full, almost_empty} for a given occupancy.
  function automatic logic [1:0] almost_flags(input int cnt, input int afull_lvl,
                                              input int aempty_lvl);
    return {cnt >= afull_lvl, cnt <= aempty_lvl};
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_ctrl: one synchronous write port, one combinational read port.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  logic [DATA_SIZE-1:0] mem_q [(1 << ADDR_SIZE)];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, registered flags/count, sticky errors and registered read port.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through (head word preloaded into rdata).
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 wfull,
  output logic                 walmost_full,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   count,
  input  logic                 err_clr,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [1:0] ALM_RST = almost_flags(0, AFULL_LEVEL, AEMPTY_LEVEL);

  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic                 full_q, empty_q, afull_q, aempty_q;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d, ram_rdata;
  logic [ADDR_SIZE-1:0] raddr;
  logic [1:0]           alm_d;
  logic                 wr_acc, rd_acc;
  rd_state_e            st_q, st_d;

  sync_fifo_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_acc),
    .waddr_i(wptr_q[ADDR_SIZE-1:0]),
    .wdata_i(wdata),
    .raddr_i(raddr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    wr_acc = winc && !full_q;
`ifdef SYNC_FIFO_FWFT_EN
    rd_acc = rinc && (st_q == RD_VALID);
`else
    rd_acc = rinc && !empty_q;
`endif
    wptr_d = wptr_q + {{ADDR_SIZE{1'b0}}, wr_acc};
    rptr_d = rptr_q + {{ADDR_SIZE{1'b0}}, rd_acc};
    cnt_d  = wptr_d - rptr_d;
    alm_d  = almost_flags(int'(cnt_d), AFULL_LEVEL, AEMPTY_LEVEL);
    // A rejected request always sets its flag, even alongside err_clr.
    ovf_d  = (winc && !wr_acc) || (ovf_q && !err_clr);
    udf_d  = (rinc && !rd_acc) || (udf_q && !err_clr);

    st_d    = RD_IDLE;
    rdata_d = rdata_q;
    raddr   = rptr_q[ADDR_SIZE-1:0];
`ifdef SYNC_FIFO_FWFT_EN
    // The displayed word stays in memory until popped; only words written
    // before this edge can be preloaded, so a same-edge write shows next cycle.
    if (rd_acc) begin
      raddr = rptr_d[ADDR_SIZE-1:0];
      if (wptr_q != rptr_d) begin
        st_d    = RD_VALID;
        rdata_d = ram_rdata;
      end
    end else if (st_q == RD_VALID) begin
      st_d = RD_VALID;
    end else if (!empty_q) begin
      st_d    = RD_VALID;
      rdata_d = ram_rdata;
    end
`else
    if (rd_acc) begin
      st_d    = RD_VALID;
      rdata_d = ram_rdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= ALM_RST[1];
      aempty_q <= ALM_RST[0];
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rdata_q  <= '0;
      st_q     <= RD_IDLE;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (wptr_d[ADDR_SIZE] != rptr_d[ADDR_SIZE]) &&
                  (wptr_d[ADDR_SIZE-1:0] == rptr_d[ADDR_SIZE-1:0]);
      empty_q  <= (wptr_d == rptr_d);
      afull_q  <= alm_d[1];
      aempty_q <= alm_d[0];
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rdata_q  <= rdata_d;
      st_q     <= st_d;
    end
  end

  assign wfull         = full_q;
  assign rempty        = empty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = cnt_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign rdata         = rdata_q;
  assign rvalid        = (st_q == RD_VALID);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model compared every cycle, plus directed literal checks.
module tb_sync_fifo_ctrl;

  localparam int DW = 8, AW = 4, DEPTH = 16, AFL = 14, AEL = 2;

  logic          clk = 1'b0;
  logic          rst, winc, rinc, err_clr;
  logic [DW-1:0] wdata;
  logic          wfull, walmost_full, rvalid, rempty, ralmost_empty, overflow, underflow;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;

  sync_fifo_ctrl #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .AFULL_LEVEL(AFL), .AEMPTY_LEVEL(AEL)
  ) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull),
    .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rvalid(rvalid),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  logic [DW-1:0] q[$];
  logic          m_rvalid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, outputs derived from its size.
  always @(posedge clk) begin : mdl
    int n;
    bit wacc, racc;
    n = q.size();
    if (rst) begin
      q.delete();
      m_rvalid = 1'b0; m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0; m_ok = 1'b1;
    end else begin
      wacc = winc && (n < DEPTH);
`ifdef SYNC_FIFO_FWFT_EN
      racc = rinc && m_rvalid;
      if (racc) begin
        void'(q.pop_front());
        if (n > 1) m_rdata = q[0];
        else m_rvalid = 1'b0;
      end else if (!m_rvalid && n > 0) begin
        m_rvalid = 1'b1;
        m_rdata  = q[0];
      end
`else
      racc = rinc && (n > 0);
      m_rvalid = racc;
      if (racc) m_rdata = q.pop_front();
`endif
      if (wacc) q.push_back(wdata);
      if (winc && !wacc) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (rinc && !racc) m_udf = 1'b1; else if (err_clr) m_udf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("count",         32'(count),         32'(q.size()));
      check("wfull",         32'(wfull),         32'(q.size() == DEPTH));
      check("rempty",        32'(rempty),        32'(q.size() == 0));
      check("walmost_full",  32'(walmost_full),  32'(q.size() >= AFL));
      check("ralmost_empty", 32'(ralmost_empty), 32'(q.size() <= AEL));
      check("rvalid",        32'(rvalid),        32'(m_rvalid));
      check("rdata",         32'(rdata),         32'(m_rdata));
      check("overflow",      32'(overflow),      32'(m_ovf));
      check("underflow",     32'(underflow),     32'(m_udf));
    end
  end

  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    @(negedge clk);
    winc = w; wdata = d; rinc = r; err_clr = c;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;
    idle(); idle();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_rempty", 32'(rempty), 1);
    check("rst_wfull", 32'(wfull), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_ralmost_empty", 32'(ralmost_empty), 1);
    check("rst_walmost_full", 32'(walmost_full), 0);

    // Fill with 0x00..0x0F, then a rejected 17th write.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 13) check("afull_at_13", 32'(walmost_full), 0);
      if (i == 14) check("afull_at_14", 32'(walmost_full), 1);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    check("full_flag", 32'(wfull), 1);
    check("full_count", 32'(count), 16);
    idle();
    check("ovf_17th", 32'(overflow), 1);
    check("count_after_17th", 32'(count), 16);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("fwft_head_valid", 32'(rvalid), 1);
      check("fwft_head_data", 32'(rdata), 32'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
`else
      drive(1'b0, '0, 1'b1, 1'b0);
      idle();
      check("rd_valid", 32'(rvalid), 1);
      check("rd_data", 32'(rdata), 32'(i));
`endif
    end
    idle();
    check("drained_empty", 32'(rempty), 1);
    check("drained_rvalid", 32'(rvalid), 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("udf_extra_rd", 32'(underflow), 1);

    drive(1'b0, '0, 1'b0, 1'b1);
    idle();
    check("clr_ovf", 32'(overflow), 0);
    check("clr_udf", 32'(underflow), 0);

    // Streaming at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      if (i > 0) begin
        check("stream_count", 32'(count), 3);
        check("stream_rvalid", 32'(rvalid), 1);
      end
    end
    idle();
    check("stream_end_count", 32'(count), 3);

    // Full with simultaneous read and write; then err_clr racing an overflow.
    for (int i = 0; i < 13; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    idle();
    check("refill_full", 32'(wfull), 1);
    drive(1'b1, 8'hBB, 1'b1, 1'b0);
    idle();
    check("full_rw_ovf", 32'(overflow), 1);
    check("full_rw_count", 32'(count), 15);
    drive(1'b1, 8'hCC, 1'b0, 1'b0);
    drive(1'b1, 8'hDD, 1'b0, 1'b1);
    idle();
    check("clr_vs_ovf", 32'(overflow), 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    idle();
    check("clr_ovf2", 32'(overflow), 0);

    // Empty with simultaneous read and write.
    for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b1, 1'b0);
    idle(); idle();
    drive(1'b0, '0, 1'b0, 1'b1);
    idle();
    check("empty_pre", 32'(rempty), 1);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    idle();
    check("empty_rw_count", 32'(count), 1);
    check("empty_rw_udf", 32'(underflow), 1);

    // Reset mid-operation at count 9, then 0xA5 round-trip.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    idle();
    check("pre_rst_count", 32'(count), 9);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("midrst_count", 32'(count), 0);
    check("midrst_rempty", 32'(rempty), 1);
    check("midrst_rvalid", 32'(rvalid), 0);
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    idle();
    check("fwft_one_edge", 32'(rvalid), 0);
    idle();
    check("fwft_two_edges", 32'(rvalid), 1);
    check("a5_data", 32'(rdata), 32'h A5);
    drive(1'b0, '0, 1'b1, 1'b0);
`else
    drive(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("a5_valid", 32'(rvalid), 1);
    check("a5_data", 32'(rdata), 32'h A5);
`endif
    idle();

    // Randomised traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = ((i / 250) % 2 == 0) ? 75 : 30;
      drive($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (105 - pw),
            $urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
